pattern_scan_scheduler: RTL

- Round-robin scheduler that shares one serial sequence-detector (Moore FSM, serial input, "1 then 0" detection output) among N_REQ requesters.
- Each requester submits a FRAME_W-bit word. The block grants one requester, clears the detector, shifts the word in MSB first, counts detector output rising edges, and returns count plus requester ID.
- The block sits between the requester ports and the shared detector instance.

---
 rtl/pattern_scan_scheduler.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pattern_scan_scheduler.sv
// Round-robin front end that time-shares one serial "1 then 0" detector among N_REQ requesters.
// Each granted frame is shifted MSB first into the detector, and the rising edges of its output are counted.
module pattern_scan_scheduler #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int FRAME_W = 8,
    parameter int CNT_W   = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*FRAME_W-1:0]   frame_data,
    output logic [N_REQ-1:0]           gnt,
    output logic                       det_clr,
    output logic                       det_in,
    input  logic                       det_out,
    output logic                       done,
    output logic [CNT_W-1:0]           result_cnt,
    output logic [ID_W-1:0]            result_id
);

    localparam int                BI_W    = $clog2(FRAME_W);
    localparam logic [BI_W-1:0]   BI_TOP  = BI_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
    localparam logic [ID_W-1:0]   RR_INIT = ID_W'(N_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_rr;
    logic [ID_W-1:0]     r_id;
    logic [ID_W-1:0]     r_result_id;
    logic [FRAME_W-1:0]  r_frame;
    logic [BI_W-1:0]     r_bit_idx;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    r_result_cnt;
    logic                r_prev;
    logic                w_found;
    logic [ID_W-1:0]     w_sel;
    logic [N_REQ-1:0]    w_gnt;
    logic                w_rise;
    logic [CNT_W-1:0]    w_cnt_nxt;

    // Round-robin search: first set request strictly after the last winner, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_sel   = {ID_W{1'b0}};
        for (int k = 1; k <= N_REQ; k++) begin
            if (!w_found && req[(int'(r_rr) + k) % N_REQ]) begin
                w_found = 1'b1;
                w_sel   = ID_W'((int'(r_rr) + k) % N_REQ);
            end else begin
                w_found = w_found;
            end
        end
    end

    // Grant is issued in the same IDLE cycle in which the frame is captured.
    always_comb begin
        w_gnt = {N_REQ{1'b0}};
        if ((r_state == S_IDLE) && w_found) begin
            w_gnt = N_REQ'(1) << w_sel;
        end else begin
            w_gnt = {N_REQ{1'b0}};
        end
    end

    // Detector output edge counter, saturating at all-ones.
    always_comb begin
        w_rise    = det_out & ~r_prev;
        w_cnt_nxt = r_cnt;
        if (w_rise && (r_cnt != CNT_MAX)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Next-state decode of the scan sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_CLEAR;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CLEAR: w_state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (r_bit_idx == {BI_W{1'b0}}) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_DRAIN: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: frame capture, shift index, edge count and the held result.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rr         <= RR_INIT;
            r_id         <= {ID_W{1'b0}};
            r_frame      <= {FRAME_W{1'b0}};
            r_bit_idx    <= {BI_W{1'b0}};
            r_cnt        <= {CNT_W{1'b0}};
            r_prev       <= 1'b0;
            r_result_cnt <= {CNT_W{1'b0}};
            r_result_id  <= {ID_W{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_frame <= frame_data[int'(w_sel) * FRAME_W +: FRAME_W];
                        r_id    <= w_sel;
                        r_rr    <= w_sel;
                    end
                end
                S_CLEAR: begin
                    r_bit_idx <= BI_TOP;
                    r_cnt     <= {CNT_W{1'b0}};
                    r_prev    <= 1'b0;
                end
                S_SHIFT: begin
                    r_cnt     <= w_cnt_nxt;
                    r_prev    <= det_out;
                    r_bit_idx <= r_bit_idx - BI_W'(1);
                end
                S_DRAIN: begin
                    // The last shifted bit only shows on det_out now, so fold this sample into the result.
                    r_cnt        <= w_cnt_nxt;
                    r_prev       <= det_out;
                    r_result_cnt <= w_cnt_nxt;
                    r_result_id  <= r_id;
                end
                S_DONE: begin
                    r_prev <= r_prev;
                end
                default: begin
                    r_prev <= 1'b0;
                end
            endcase
        end
    end

    assign gnt        = w_gnt;
    assign det_clr    = RST | (r_state == S_CLEAR);
    assign det_in     = (r_state == S_SHIFT) ? r_frame[r_bit_idx] : 1'b0;
    assign done       = (r_state == S_DONE);
    assign result_cnt = r_result_cnt;
    assign result_id  = r_result_id;

endmodule
